// File: rtl/count_wrap_monitor_pkg.sv
// count_wrap_monitor_pkg: event codes, tracker state encoding and the
// seven-segment pattern table shared by the count_wrap_monitor slice.
package count_wrap_monitor_pkg;

  // Event classes carried on evt_code
  localparam logic [2:0] EVT_NONE         = 3'd0;
  localparam logic [2:0] EVT_STEP_UP      = 3'd1;
  localparam logic [2:0] EVT_STEP_DOWN    = 3'd2;
  localparam logic [2:0] EVT_WRAP_UP      = 3'd3;
  localparam logic [2:0] EVT_WRAP_DOWN    = 3'd4;
  localparam logic [2:0] EVT_DIR_MISMATCH = 3'd5;
  localparam logic [2:0] EVT_JUMP         = 3'd6;

  // Tracker state: INIT waits for the first settled sample, TRACK classifies
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Hex digit patterns, bit order {g,f,e,d,c,b,a}; entry 15 first so that
  // SEG_LUT[digit] selects the pattern for that digit.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/count_wrap_monitor_if.sv
// count_wrap_monitor_if: one-deep event slot handshake (valid/ready plus
// event payload). master = monitor side, slave = consumer side.
interface count_wrap_monitor_if #(
  parameter int WIDTH = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_code;
  logic [WIDTH-1:0] evt_value;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_value,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_value,
    output evt_ready
  );
endinterface

// File: rtl/count_wrap_monitor_q_sync_filter.sv
// q_sync_filter: three-flop synchroniser for the {m, q} bus with a settle
// check (s2 == s3). The stable flag is held off until the pipe has been
// refilled with real samples after reset, so the reset zeros are never
// mistaken for a counter value.
module q_sync_filter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         stable,
  output logic [W-1:0] value
);

  logic [W-1:0] s1_reg;
  logic [W-1:0] s2_reg;
  logic [W-1:0] s3_reg;
  logic [1:0]   fill_reg;

  // Synchroniser chain
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // Counts edges since reset until s3 holds a genuine sample
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fill_reg <= 2'd0;
    end else if (fill_reg != 2'd3) begin
      fill_reg <= fill_reg + 2'd1;
    end
  end

  assign stable = (fill_reg == 2'd3) && (s2_reg == s3_reg);
  assign value  = s3_reg;

endmodule

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: watches a ripple up/down counter (q, m), accepts only
// settled values, classifies each change and keeps a signed wrap epoch.
// Events leave through a one-deep valid/ready slot.
// Optional: define COUNT_WRAP_MONITOR_SEVEN_SEG_EN to add a registered
// seven-segment display (seg) of the last accepted value.
module count_wrap_monitor
  import count_wrap_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [WIDTH-1:0]   q,
  input  logic               m,
  input  logic               err_clr,
  count_wrap_monitor_if.master evt,
  output logic [EPOCH_W-1:0] epoch,
  output logic               err,
  output logic               ovf
`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
  ,
  output logic [6:0]         seg
`endif
);

  localparam logic [WIDTH-1:0]   Q_MAX     = '1;
  localparam logic [WIDTH-1:0]   Q_ONE     = WIDTH'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  logic             sync_stable;
  logic [WIDTH:0]   sync_value;
  logic [WIDTH-1:0] sync_q;
  logic             sync_m;

  state_t           state_reg;
  state_t           state_next;
  logic             load_init;
  logic             accept;
  logic [2:0]       code_next;

  logic [WIDTH-1:0]   last_reg;
  logic [EPOCH_W-1:0] epoch_reg;
  logic               err_reg;
  logic               ovf_reg;
  logic               valid_reg;
  logic [2:0]         code_reg;
  logic [WIDTH-1:0]   value_reg;

  logic up_ok;
  logic down_ok;
  logic wrap_up_ok;
  logic wrap_down_ok;
  logic drop;

  q_sync_filter #(
    .W(WIDTH + 1)
  ) u_sync (
    .clk    (clk),
    .clr    (clr),
    .d      ({m, q}),
    .stable (sync_stable),
    .value  (sync_value)
  );

  assign sync_q = sync_value[WIDTH-1:0];
  assign sync_m = sync_value[WIDTH];

  // Tracker state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Leave INIT once the first settled sample has been captured
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && sync_stable) begin
      state_next = ST_TRACK;
    end
  end

  // Tracker outputs: initial load vs. accepted change
  always_comb begin
    load_init = 1'b0;
    accept    = 1'b0;
    if (state_reg == ST_INIT) begin
      load_init = sync_stable;
    end else begin
      accept = sync_stable && (sync_q != last_reg);
    end
  end

  // Classify the settled value against the last accepted one
  always_comb begin
    up_ok        = (sync_q == last_reg + Q_ONE) && (last_reg != Q_MAX);
    down_ok      = (sync_q == last_reg - Q_ONE) && (last_reg != '0);
    wrap_up_ok   = (last_reg == Q_MAX) && (sync_q == '0);
    wrap_down_ok = (last_reg == '0) && (sync_q == Q_MAX);
    code_next    = EVT_JUMP;
    if (!sync_m) begin
      if (up_ok)                        code_next = EVT_STEP_UP;
      else if (wrap_up_ok)              code_next = EVT_WRAP_UP;
      else if (down_ok || wrap_down_ok) code_next = EVT_DIR_MISMATCH;
    end else begin
      if (down_ok)                      code_next = EVT_STEP_DOWN;
      else if (wrap_down_ok)            code_next = EVT_WRAP_DOWN;
      else if (up_ok || wrap_up_ok)     code_next = EVT_DIR_MISMATCH;
    end
  end

  // Last accepted value and wrap epoch track every accepted change,
  // even one whose event is dropped
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      last_reg  <= '0;
      epoch_reg <= '0;
    end else begin
      if (load_init || accept) begin
        last_reg <= sync_q;
      end
      if (accept && code_next == EVT_WRAP_UP) begin
        epoch_reg <= epoch_reg + EPOCH_ONE;
      end else if (accept && code_next == EVT_WRAP_DOWN) begin
        epoch_reg <= epoch_reg - EPOCH_ONE;
      end
    end
  end

  assign drop = accept && valid_reg && !evt.evt_ready;

  // One-deep event slot; a consumer taking the pending event frees the slot
  // for a new event in the same cycle. Code reads NONE whenever empty.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_reg <= 1'b0;
      code_reg  <= EVT_NONE;
      value_reg <= '0;
    end else if (accept && (!valid_reg || evt.evt_ready)) begin
      valid_reg <= 1'b1;
      code_reg  <= code_next;
      value_reg <= sync_q;
    end else if (valid_reg && evt.evt_ready) begin
      valid_reg <= 1'b0;
      code_reg  <= EVT_NONE;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (accept && (code_next == EVT_DIR_MISMATCH || code_next == EVT_JUMP)) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (err_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = valid_reg;
  assign evt.evt_code  = code_reg;
  assign evt.evt_value = value_reg;
  assign epoch         = epoch_reg;
  assign err           = err_reg;
  assign ovf           = ovf_reg;

`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
  logic [6:0] seg_reg;

  // Display follows the last accepted value one cycle later
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      seg_reg <= 7'd0;
    end else begin
      seg_reg <= SEG_LUT[4'(last_reg)];
    end
  end

  assign seg = seg_reg;
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: directed vectors with hand-computed expectations.
module tb_count_wrap_monitor;
  import count_wrap_monitor_pkg::*;

  logic       clk;
  logic       clr;
  logic [3:0] q;
  logic       m;
  logic       err_clr;
  logic [7:0] epoch;
  logic       err;
  logic       ovf;
`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
  logic [6:0] seg;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic saw_valid;

  count_wrap_monitor_if #(.WIDTH(4)) evt_if ();

  count_wrap_monitor #(
    .WIDTH   (4),
    .EPOCH_W (8)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .q       (q),
    .m       (m),
    .err_clr (err_clr),
    .evt     (evt_if),
    .epoch   (epoch),
    .err     (err),
    .ovf     (ovf)
`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
    ,
    .seg     (seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new counter value and wait until its event would be visible
  task automatic apply(input logic [3:0] qv, input logic mv);
    q = qv;
    m = mv;
    repeat (4) tick();
  endtask

  task automatic expect_evt(input string tag, input logic [2:0] code, input logic [3:0] value);
    check_val({tag, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
    check_val({tag, ".code"},  32'(evt_if.evt_code),  32'(code));
    check_val({tag, ".value"}, 32'(evt_if.evt_value), 32'(value));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    q = 4'd5;
    m = 1'b0;
    err_clr = 1'b0;
    evt_if.evt_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check_val("rst.valid", 32'(evt_if.evt_valid), 32'd0);
    check_val("rst.code",  32'(evt_if.evt_code),  32'd0);
    check_val("rst.epoch", 32'(epoch), 32'd0);
    check_val("rst.err",   32'(err), 32'd0);
    check_val("rst.ovf",   32'(ovf), 32'd0);

    // First settled sample loads L without an event
    clr = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_if.evt_valid) saw_valid = 1'b1;
    end
    check_val("init.noevt", 32'(saw_valid), 32'd0);
    check_val("init.state", 32'(dut.state_reg), 32'(ST_TRACK));
    check_val("init.last",  32'(dut.last_reg), 32'd5);

    // Latency: valid after edge 4, not edge 3
    q = 4'd6;
    repeat (3) tick();
    check_val("lat.edge3", 32'(evt_if.evt_valid), 32'd0);
    tick();
    expect_evt("step56", EVT_STEP_UP, 4'd6);
    check_val("step56.epoch", 32'(epoch), 32'd0);
    tick();
    check_val("drain.valid", 32'(evt_if.evt_valid), 32'd0);
    check_val("drain.code",  32'(evt_if.evt_code),  32'd0);

    // Up sequence through the wrap
    apply(4'd14, 1'b0);
    expect_evt("jump6_14", EVT_JUMP, 4'd14);
    pulse_err_clr();
    check_val("errclr1", 32'(err), 32'd0);
    apply(4'd15, 1'b0);
    expect_evt("up15", EVT_STEP_UP, 4'd15);
    apply(4'd0, 1'b0);
    expect_evt("wrapup", EVT_WRAP_UP, 4'd0);
    check_val("wrapup.epoch", 32'(epoch), 32'd1);

    // Down sequence back through the wrap
    apply(4'd1, 1'b0);
    expect_evt("up1", EVT_STEP_UP, 4'd1);
    apply(4'd0, 1'b1);
    expect_evt("down0", EVT_STEP_DOWN, 4'd0);
    apply(4'd15, 1'b1);
    expect_evt("wrapdn", EVT_WRAP_DOWN, 4'd15);
    check_val("wrapdn.epoch", 32'(epoch), 32'd0);
    check_val("wrapdn.err", 32'(err), 32'd0);

    // Wrap-shaped move with wrong mode: mismatch, epoch untouched
    apply(4'd0, 1'b1);
    expect_evt("mm_wrap", EVT_DIR_MISMATCH, 4'd0);
    check_val("mm_wrap.epoch", 32'(epoch), 32'd0);
    check_val("mm_wrap.err", 32'(err), 32'd1);
    // Epoch underflows to all ones
    apply(4'd15, 1'b1);
    expect_evt("wrapdn2", EVT_WRAP_DOWN, 4'd15);
    check_val("wrapdn2.epoch", 32'(epoch), 32'hFF);
    apply(4'd0, 1'b1);
    apply(4'd1, 1'b0);
    apply(4'd2, 1'b0);
    apply(4'd3, 1'b0);
    expect_evt("up3", EVT_STEP_UP, 4'd3);
    pulse_err_clr();
    check_val("errclr2", 32'(err), 32'd0);

    // One-cycle glitch is never accepted
    q = 4'd7;
    tick();
    q = 4'd3;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_if.evt_valid) saw_valid = 1'b1;
    end
    check_val("glitch.noevt", 32'(saw_valid), 32'd0);
    check_val("glitch.last", 32'(dut.last_reg), 32'd3);

    // Jump sets err, err_clr clears it
    apply(4'd9, 1'b0);
    expect_evt("jump3_9", EVT_JUMP, 4'd9);
    check_val("jump.err", 32'(err), 32'd1);
    pulse_err_clr();
    check_val("errclr3", 32'(err), 32'd0);

    // Set beats clear in the same cycle
    err_clr = 1'b1;
    apply(4'd12, 1'b0);
    expect_evt("jump9_12", EVT_JUMP, 4'd12);
    check_val("setwins.err", 32'(err), 32'd1);
    err_clr = 1'b0;

    // Backpressure
    apply(4'd2, 1'b0);
    tick();
    evt_if.evt_ready = 1'b0;
    pulse_err_clr();
    check_val("bp.err0", 32'(err), 32'd0);
    apply(4'd3, 1'b0);
    expect_evt("bp.first", EVT_STEP_UP, 4'd3);
    apply(4'd4, 1'b0);
    expect_evt("bp.held", EVT_STEP_UP, 4'd3);
    check_val("bp.ovf", 32'(ovf), 32'd1);
    check_val("bp.last", 32'(dut.last_reg), 32'd4);
    check_val("bp.epoch", 32'(epoch), 32'hFF);
    pulse_err_clr();
    check_val("bp.ovfclr", 32'(ovf), 32'd0);
    check_val("bp.stillvalid", 32'(evt_if.evt_valid), 32'd1);
    q = 4'd5;
    repeat (3) tick();
    evt_if.evt_ready = 1'b1;
    tick();
    expect_evt("bp.replace", EVT_STEP_UP, 4'd5);
    check_val("bp.noovf", 32'(ovf), 32'd0);

    // Asynchronous reset mid-operation
    clr = 1'b0;
    q = 4'd10;
    m = 1'b0;
    #2;
    check_val("arst.valid", 32'(evt_if.evt_valid), 32'd0);
    check_val("arst.code",  32'(evt_if.evt_code),  32'd0);
    check_val("arst.value", 32'(evt_if.evt_value), 32'd0);
    check_val("arst.epoch", 32'(epoch), 32'd0);
    check_val("arst.state", 32'(dut.state_reg), 32'(ST_INIT));
    repeat (2) tick();
    clr = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_if.evt_valid) saw_valid = 1'b1;
    end
    check_val("rearm.noevt", 32'(saw_valid), 32'd0);
    check_val("rearm.last", 32'(dut.last_reg), 32'd10);
`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
    check_val("seg.A", 32'(seg), 32'h77);
`endif

    // Up step seen while the counter reports down mode
    apply(4'd4, 1'b1);
    expect_evt("jump10_4", EVT_JUMP, 4'd4);
    pulse_err_clr();
    check_val("errclr4", 32'(err), 32'd0);
    apply(4'd5, 1'b1);
    expect_evt("mm_step", EVT_DIR_MISMATCH, 4'd5);
    check_val("mm_step.err", 32'(err), 32'd1);
    check_val("mm_step.epoch", 32'(epoch), 32'd0);
`ifdef COUNT_WRAP_MONITOR_SEVEN_SEG_EN
    tick();
    check_val("seg.5", 32'(seg), 32'h6D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
